// File: rtl/micro_sequencer_pkg.sv
// Shared types for the micro-sequencer: opcodes, micro-ops, sequencer states
// and the busy-gated wait classifier.
`default_nettype none

package micro_sequencer_pkg;

  localparam int SEQ_CYCLE_W = 6;

  typedef enum logic [3:0] {
    NXI  = 4'd0,
    LDAI = 4'd1,
    CPY  = 4'd2,
    ATB  = 4'd3,
    GPU  = 4'd4,
    HLT  = 4'd5,
    WTT  = 4'd6
  } Opcode_enum;

  typedef enum logic [4:0] {
    ENDMICRO   = 5'd0,
    WAIT_CYCLE = 5'd1,
    WAIT_GPU   = 5'd2,
    WAIT_MT    = 5'd3,
    WAIT_UT    = 5'd4,
    WAIT_FT    = 5'd5,
    WAIT_DD    = 5'd6,
    HLT_CLK    = 5'd7,
    MAR_PC     = 5'd8,
    LD_IR      = 5'd9,
    INC_PC     = 5'd10,
    LD_A       = 5'd11,
    ST_A       = 5'd12,
    START_GPU  = 5'd13
  } Microcode_enum;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  // WAIT_CYCLE is deliberately excluded: it has no busy line and never stalls.
  function automatic logic is_wait_uop(input Microcode_enum u);
    return (u == WAIT_GPU) || (u == WAIT_MT) || (u == WAIT_UT) ||
           (u == WAIT_FT)  || (u == WAIT_DD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/micro_stall_mux.sv
// Combinational selection of the peripheral busy line named by the current
// WAIT_* micro-op; stall is high only while that peripheral is busy.
`default_nettype none

module micro_stall_mux
  import micro_sequencer_pkg::*;
(
  input  Microcode_enum ucode,
  input  logic          gpu_busy,
  input  logic          mt_busy,
  input  logic          ut_busy,
  input  logic          ft_busy,
  input  logic          dd_busy,
  output logic          stall
);

  always_comb begin
    stall = 1'b0;
    if (is_wait_uop(ucode)) begin
      case (ucode)
        WAIT_GPU: stall = gpu_busy;
        WAIT_MT:  stall = mt_busy;
        WAIT_UT:  stall = ut_busy;
        WAIT_FT:  stall = ft_busy;
        WAIT_DD:  stall = dd_busy;
        default:  stall = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/micro_sequencer.sv
// Fetch/execute micro-sequencer driving {operation, cycle} into the microcode
// decoder. Optional single-step mode: define MICRO_SEQ_SINGLE_STEP_EN.
`default_nettype none

module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int MAX_CYCLES = 32,
  parameter int RETIRE_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  Microcode_enum          ucode,
  input  Opcode_enum             ir_opcode,
  input  logic                   gpu_busy,
  input  logic                   mt_busy,
  input  logic                   ut_busy,
  input  logic                   ft_busy,
  input  logic                   dd_busy,
  input  logic                   resume,
`ifdef MICRO_SEQ_SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step,
`endif
  output Opcode_enum             operation,
  output logic [SEQ_CYCLE_W-1:0] cycle,
  output logic                   ucode_en,
  output logic                   halted,
  output logic                   wd_fault,
  output logic [RETIRE_W-1:0]    retired
);

  if (MAX_CYCLES < 1 || MAX_CYCLES > 64) begin : g_max_cycles_bad
    $error("micro_sequencer: MAX_CYCLES must be in 1..64");
  end

  localparam logic [SEQ_CYCLE_W-1:0] WD_LAST = SEQ_CYCLE_W'(MAX_CYCLES - 1);

  seq_state_e                state_q, state_d;
  seq_state_e                prev_q, prev_d;
  logic [SEQ_CYCLE_W-1:0]    cycle_q, cycle_d;
  Opcode_enum                op_q, op_d;
  logic                      wd_fault_q, wd_fault_d;
  logic [RETIRE_W-1:0]       retired_q, retired_d;
  logic                      stall;
  logic                      exec_ok;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
  logic                      step_halt_q, step_halt_d;
`endif

  micro_stall_mux u_stall_mux (
    .ucode    (ucode),
    .gpu_busy (gpu_busy),
    .mt_busy  (mt_busy),
    .ut_busy  (ut_busy),
    .ft_busy  (ft_busy),
    .dd_busy  (dd_busy),
    .stall    (stall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      prev_q     <= FETCH;
      cycle_q    <= '0;
      op_q       <= NXI;
      wd_fault_q <= 1'b0;
      retired_q  <= '0;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
      step_halt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cycle_q    <= cycle_d;
      op_q       <= op_d;
      wd_fault_q <= wd_fault_d;
      retired_q  <= retired_d;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
      step_halt_q <= step_halt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cycle_d    = cycle_q;
    op_d       = op_q;
    wd_fault_d = wd_fault_q;
    retired_d  = retired_q;
    ucode_en   = 1'b0;
    exec_ok    = 1'b0;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    step_halt_d = step_halt_q;
`endif

    unique case (state_q)
      FETCH, EXEC: begin
        if (ucode == ENDMICRO) begin
          cycle_d = '0;
          if (state_q == FETCH) begin
            op_d    = ir_opcode;
            state_d = EXEC;
          end else begin
            retired_d = retired_q + 1'b1;
            state_d   = FETCH;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
            if (step_mode) begin
              state_d     = HALT;
              step_halt_d = 1'b1;
            end
`endif
          end
        end else if (stall) begin
          state_d = STALL;
          prev_d  = state_q;
        end else begin
          ucode_en = 1'b1;
          exec_ok  = 1'b1;
          // HLT_CLK keeps cycle so resume can step onto the following micro-op.
          if (ucode == HLT_CLK) begin
            state_d = HALT;
          end else begin
            cycle_d = cycle_q + 1'b1;
          end
        end
      end

      STALL: begin
        if (!stall) begin
          ucode_en = 1'b1;
          exec_ok  = 1'b1;
          state_d  = prev_q;
          cycle_d  = cycle_q + 1'b1;
        end
      end

      HALT: begin
`ifdef MICRO_SEQ_SINGLE_STEP_EN
        if (step_halt_q) begin
          if (step || resume) begin
            state_d     = FETCH;
            cycle_d     = '0;
            step_halt_d = 1'b0;
          end
        end else if (resume) begin
          state_d = EXEC;
          cycle_d = cycle_q + 1'b1;
        end
`else
        if (resume) begin
          state_d = EXEC;
          cycle_d = cycle_q + 1'b1;
        end
`endif
      end
    endcase

    // The last allowed micro-op still executes; the instruction is then abandoned.
    if (exec_ok && (cycle_q == WD_LAST)) begin
      wd_fault_d = 1'b1;
      state_d    = FETCH;
      cycle_d    = '0;
    end
  end

  assign operation = (state_q == FETCH) ? NXI : op_q;
  assign cycle     = cycle_q;
  assign halted    = (state_q == HALT);
  assign wd_fault  = wd_fault_q;
  assign retired   = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a small microcode ROM model.
`default_nettype none

module tb_micro_sequencer;
  import micro_sequencer_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  Microcode_enum ucode;
  Opcode_enum    ir_opcode = NXI;
  logic          gpu_busy = 1'b0, mt_busy = 1'b0, ut_busy = 1'b0;
  logic          ft_busy = 1'b0, dd_busy = 1'b0, resume = 1'b0;
  logic          force_inc = 1'b0;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
  logic          step_mode = 1'b0, step = 1'b0;
`endif
  Opcode_enum    operation;
  logic [5:0]    cycle;
  logic          ucode_en, halted, wd_fault;
  logic [15:0]   retired;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  micro_sequencer #(.MAX_CYCLES(32), .RETIRE_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ucode     (ucode),
    .ir_opcode (ir_opcode),
    .gpu_busy  (gpu_busy),
    .mt_busy   (mt_busy),
    .ut_busy   (ut_busy),
    .ft_busy   (ft_busy),
    .dd_busy   (dd_busy),
    .resume    (resume),
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .operation (operation),
    .cycle     (cycle),
    .ucode_en  (ucode_en),
    .halted    (halted),
    .wd_fault  (wd_fault),
    .retired   (retired)
  );

  function automatic Microcode_enum decode(input Opcode_enum op, input logic [5:0] c);
    Microcode_enum u;
    u = ENDMICRO;
    case (op)
      NXI:  case (c) 6'd0: u = MAR_PC; 6'd1: u = LD_IR; 6'd2: u = INC_PC; 6'd3: u = WAIT_CYCLE; default: u = ENDMICRO; endcase
      LDAI: case (c) 6'd0: u = MAR_PC; 6'd1: u = LD_A;  6'd2: u = INC_PC; 6'd3: u = WAIT_CYCLE; default: u = ENDMICRO; endcase
      CPY:  if (c < 6'd8) u = ST_A;
      ATB:  if (c == 6'd0) u = LD_A;
      GPU:  case (c) 6'd0: u = WAIT_GPU; 6'd1: u = START_GPU; default: u = ENDMICRO; endcase
      HLT:  if (c == 6'd0) u = HLT_CLK;
      WTT:  case (c) 6'd0: u = WAIT_MT; 6'd1: u = WAIT_DD; 6'd2: u = WAIT_CYCLE; default: u = ENDMICRO; endcase
      default: u = ENDMICRO;
    endcase
    return u;
  endfunction

  always_comb begin
    ucode = decode(operation, cycle);
    if (force_inc && operation != NXI) ucode = INC_PC;
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Runs the 5-cycle NXI fetch from FETCH/cycle 0; leaves DUT in EXEC cycle 0.
  task automatic do_fetch(input Opcode_enum op);
    ir_opcode = op;
    repeat (5) nxt();
  endtask

  task automatic test_reset_ldai();
    rst_n = 1'b0;
    ir_opcode = LDAI;
    nxt(); nxt();
    n_checks++;
    if ({operation, cycle, ucode_en, halted, wd_fault, retired} !== {NXI, 6'd0, 1'b1, 1'b0, 1'b0, 16'd0})
      $display("FAIL reset_state: got %h want %h", {operation, cycle, ucode_en, halted, wd_fault, retired}, {NXI, 6'd0, 1'b1, 1'b0, 1'b0, 16'd0});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nxt();
      n_checks++;
      if ({operation, cycle, ucode_en} !== {NXI, 6'(k), (k < 4)})
        $display("FAIL fetch_step%0d: got %h want %h", k, {operation, cycle, ucode_en}, {NXI, 6'(k), (k < 4)});
      else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      nxt();
      n_checks++;
      if ({operation, cycle, ucode_en} !== {LDAI, 6'(k), (k < 4)})
        $display("FAIL ldai_step%0d: got %h want %h", k, {operation, cycle, ucode_en}, {LDAI, 6'(k), (k < 4)});
      else n_pass++;
    end
    nxt();
    n_checks++;
    if ({operation, cycle, retired} !== {NXI, 6'd0, 16'd1})
      $display("FAIL ldai_retire: got %h want %h", {operation, cycle, retired}, {NXI, 6'd0, 16'd1});
    else n_pass++;
  endtask

  task automatic test_gpu_stall();
    do_fetch(GPU);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nxt();
      gpu_busy = (i < 7);
      #1;
      n_checks++;
      if ({operation, cycle, ucode_en} !== {GPU, 6'd0, (i == 7)})
        $display("FAIL gpu_stall%0d: got %h want %h", i, {operation, cycle, ucode_en}, {GPU, 6'd0, (i == 7)});
      else n_pass++;
    end
    nxt();
    n_checks++;
    if ({operation, cycle, ucode_en} !== {GPU, 6'd1, 1'b1})
      $display("FAIL gpu_start: got %h want %h", {operation, cycle, ucode_en}, {GPU, 6'd1, 1'b1});
    else n_pass++;
    nxt(); nxt();
    n_checks++;
    if ({operation, cycle, retired} !== {NXI, 6'd0, 16'd2})
      $display("FAIL gpu_retire: got %h want %h", {operation, cycle, retired}, {NXI, 6'd0, 16'd2});
    else n_pass++;
  endtask

  task automatic test_wait_lines();
    logic [6:0] want [6];
    want = '{{6'd0, 1'b1}, {6'd1, 1'b0}, {6'd1, 1'b0}, {6'd1, 1'b1}, {6'd2, 1'b1}, {6'd3, 1'b0}};
    gpu_busy = 1'b1; ut_busy = 1'b1; ft_busy = 1'b1; mt_busy = 1'b0; dd_busy = 1'b1;
    do_fetch(WTT);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) nxt();
      if (i == 3) dd_busy = 1'b0;
      #1;
      n_checks++;
      if ({cycle, ucode_en} !== want[i])
        $display("FAIL wait_lines%0d: got %h want %h", i, {cycle, ucode_en}, want[i]);
      else n_pass++;
    end
    nxt();
    n_checks++;
    if ({operation, cycle, retired} !== {NXI, 6'd0, 16'd3})
      $display("FAIL wait_retire: got %h want %h", {operation, cycle, retired}, {NXI, 6'd0, 16'd3});
    else n_pass++;
    gpu_busy = 1'b0; ut_busy = 1'b0; ft_busy = 1'b0;
  endtask

  task automatic test_halt();
    int bad;
    ir_opcode = HLT;
    resume = 1'b1;
    nxt();
    resume = 1'b0;
    #1;
    n_checks++;
    if ({operation, cycle, halted, ucode_en} !== {NXI, 6'd1, 1'b0, 1'b1})
      $display("FAIL resume_ignored: got %h want %h", {operation, cycle, halted, ucode_en}, {NXI, 6'd1, 1'b0, 1'b1});
    else n_pass++;
    repeat (4) nxt();
    n_checks++;
    if ({operation, cycle, ucode_en, halted} !== {HLT, 6'd0, 1'b1, 1'b0})
      $display("FAIL hlt_issue: got %h want %h", {operation, cycle, ucode_en, halted}, {HLT, 6'd0, 1'b1, 1'b0});
    else n_pass++;
    bad = 0;
    repeat (100) begin
      nxt();
      if ({cycle, halted, ucode_en} !== {6'd0, 1'b1, 1'b0}) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    nxt();
    resume = 1'b1;
    #1;
    nxt();
    resume = 1'b0;
    #1;
    n_checks++;
    if ({operation, cycle, ucode_en, halted} !== {HLT, 6'd1, 1'b0, 1'b0})
      $display("FAIL hlt_resume: got %h want %h", {operation, cycle, ucode_en, halted}, {HLT, 6'd1, 1'b0, 1'b0});
    else n_pass++;
    nxt();
    n_checks++;
    if ({operation, cycle, retired} !== {NXI, 6'd0, 16'd4})
      $display("FAIL hlt_retire: got %h want %h", {operation, cycle, retired}, {NXI, 6'd0, 16'd4});
    else n_pass++;
  endtask

  task automatic test_watchdog();
    force_inc = 1'b1;
    do_fetch(LDAI);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) nxt();
      n_checks++;
      if ({operation, cycle, ucode_en, wd_fault} !== {LDAI, 6'(k), 1'b1, 1'b0})
        $display("FAIL wd_run%0d: got %h want %h", k, {operation, cycle, ucode_en, wd_fault}, {LDAI, 6'(k), 1'b1, 1'b0});
      else n_pass++;
    end
    nxt();
    force_inc = 1'b0;
    #1;
    n_checks++;
    if ({operation, cycle, wd_fault, retired} !== {NXI, 6'd0, 1'b1, 16'd4})
      $display("FAIL wd_fire: got %h want %h", {operation, cycle, wd_fault, retired}, {NXI, 6'd0, 1'b1, 16'd4});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_fetch(CPY);
    repeat (6) nxt();
    n_checks++;
    if ({operation, cycle, ucode_en} !== {CPY, 6'd6, 1'b1})
      $display("FAIL cpy_mid: got %h want %h", {operation, cycle, ucode_en}, {CPY, 6'd6, 1'b1});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({operation, cycle, ucode_en, halted, wd_fault, retired} !== {NXI, 6'd0, 1'b1, 1'b0, 1'b0, 16'd0})
      $display("FAIL async_reset: got %h want %h", {operation, cycle, ucode_en, halted, wd_fault, retired}, {NXI, 6'd0, 1'b1, 1'b0, 1'b0, 16'd0});
    else n_pass++;
    nxt();
    rst_n = 1'b1;
    #1;
  endtask

`ifdef MICRO_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    step_mode = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      do_fetch(ATB);
      n_checks++;
      if ({operation, cycle, ucode_en} !== {ATB, 6'd0, 1'b1})
        $display("FAIL atb_exec%0d: got %h want %h", n, {operation, cycle, ucode_en}, {ATB, 6'd0, 1'b1});
      else n_pass++;
      nxt();
      nxt();
      n_checks++;
      if ({halted, retired} !== {1'b1, 16'(n)})
        $display("FAIL step_halt%0d: got %h want %h", n, {halted, retired}, {1'b1, 16'(n)});
      else n_pass++;
      nxt();
      step = 1'b1;
      #1;
      nxt();
      step = 1'b0;
      #1;
      n_checks++;
      if ({operation, cycle, halted} !== {NXI, 6'd0, 1'b0})
        $display("FAIL step_go%0d: got %h want %h", n, {operation, cycle, halted}, {NXI, 6'd0, 1'b0});
      else n_pass++;
    end
    step_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset_ldai();
    test_gpu_stall();
    test_wait_lines();
    test_halt();
    test_watchdog();
    test_async_reset();
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
